// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and constants for the matrix result collector.
// Holds the collector FSM state encoding, the default geometry and the
// helper that sizes row/column counters from the matrix dimension.
package matrix_pkg;

  // Collector FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // Default geometry: 4x4 matrix of IEEE-754 singles, 5-bit index fields
  localparam int MAT_M      = 4;
  localparam int MAT_IDX_W  = 5;
  localparam int MAT_DATA_W = 32;

  // Bits needed to address 0..m-1, never less than one bit
  function automatic int idx_bits(input int m);
    if (m > 1) begin
      return $clog2(m);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/matrix_result_collector_if.sv
// matrix_result_collector_if: result-capture handshake from the multiplier,
// drain stream towards the consumer, and collector status.
// The slave modport is the collector's view; master is the environment's.
interface matrix_result_collector_if
  import matrix_pkg::*;
#(
  parameter int IDX_W  = MAT_IDX_W,
  parameter int DATA_W = MAT_DATA_W
);

  // control
  logic              start;
  logic              mm_done;
  // capture side
  logic [DATA_W-1:0] z_in;
  logic [IDX_W-1:0]  z_i;
  logic [IDX_W-1:0]  z_j;
  logic              z_stb;
  logic              z_ack;
  // drain side
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_row;
  logic [IDX_W-1:0]  out_col;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  // status
  logic              busy;
  logic [15:0]       wr_count;
  logic              idx_err;

  modport slave (
    input  start, mm_done, z_in, z_i, z_j, z_stb, out_ready,
    output z_ack, out_data, out_row, out_col, out_valid, out_last,
           busy, wr_count, idx_err
  );

  modport master (
    output start, mm_done, z_in, z_i, z_j, z_stb, out_ready,
    input  z_ack, out_data, out_row, out_col, out_valid, out_last,
           busy, wr_count, idx_err
  );

endinterface

// File: rtl/matrix_regfile.sv
// matrix_regfile: M x M x DATA_W register-file image of the result matrix.
// One synchronous write port, one combinational read port, synchronous
// clear-all and asynchronous reset to zero. Writes outside the M x M
// footprint (possible for non power-of-two M) are dropped.
module matrix_regfile
  import matrix_pkg::*;
#(
  parameter int M      = MAT_M,
  parameter int DATA_W = MAT_DATA_W,
  parameter int AW     = idx_bits(M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     wr_row,
  input  logic [AW-1:0]     wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_row,
  input  logic [AW-1:0]     rd_col,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = M * M;
  localparam int LW    = idx_bits(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [LW-1:0]     wr_addr_s;
  logic [LW-1:0]     rd_addr_s;
  logic              wr_ok_s;

  assign wr_addr_s = LW'(wr_row) * LW'(M) + LW'(wr_col);
  assign rd_addr_s = LW'(rd_row) * LW'(M) + LW'(rd_col);
  assign wr_ok_s   = we && ({1'b0, wr_row} < (AW+1)'(M))
                        && ({1'b0, wr_col} < (AW+1)'(M));
  assign rd_data   = mem_r[rd_addr_s];

  // Storage: reset/clear wipe the whole image, otherwise single-word write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= {DATA_W{1'b0}};
      end
    end else if (clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[wr_addr_s] <= wr_data;
    end
  end

endmodule

// File: rtl/matrix_result_collector.sv
// matrix_result_collector: captures indexed result words from the
// sequential matrix multiplier into an M x M image (last write per element
// wins) and, on the multiplier's done pulse, streams the matrix out
// row-major over a valid/ready port.
// Optional feature macro: MATRIX_COLLECT_RANGE_CHECK_EN -- when defined,
// out-of-range indices are acked but not written and raise sticky idx_err;
// when undefined, indices are truncated and idx_err is tied low.
module matrix_result_collector
  import matrix_pkg::*;
#(
  parameter int M      = MAT_M,
  parameter int IDX_W  = MAT_IDX_W,
  parameter int DATA_W = MAT_DATA_W
) (
  input logic                      clk,
  input logic                      rst,
  matrix_result_collector_if.slave bus
);

  localparam int               AW      = idx_bits(M);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(M - 1);
  localparam logic [AW-1:0]    LAST_RC = AW'(M - 1);

  state_e            state_r;
  state_e            next_state_s;

  logic              z_ack_r;
  logic [15:0]       wr_count_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic [DATA_W-1:0] out_data_r;
  logic [AW-1:0]     row_r;
  logic [AW-1:0]     col_r;

  logic              busy_s;
  logic              clr_s;
  logic              cap_s;
  logic              wr_en_s;
  logic              drain_go_s;
  logic              fire_s;
  logic              last_s;
  logic              last_fire_s;
  logic [AW-1:0]     wr_row_s;
  logic [AW-1:0]     wr_col_s;
  logic [AW-1:0]     nxt_row_s;
  logic [AW-1:0]     nxt_col_s;
  logic [AW-1:0]     rd_row_s;
  logic [AW-1:0]     rd_col_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] first_data_s;

  // Write address is the low index bits; with range checking enabled an
  // in-range index has no upper bits set, so both builds share this path.
  assign wr_row_s = bus.z_i[AW-1:0];
  assign wr_col_s = bus.z_j[AW-1:0];

`ifdef MATRIX_COLLECT_RANGE_CHECK_EN
  logic in_range_s;
  logic idx_err_r;

  assign in_range_s  = (bus.z_i <= MAX_IDX) && (bus.z_j <= MAX_IDX);
  assign wr_en_s     = cap_s && in_range_s;
  assign bus.idx_err = idx_err_r;

  // Sticky index error: set by an out-of-range capture, cleared by start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_err_r <= 1'b0;
    end else if (clr_s) begin
      idx_err_r <= 1'b0;
    end else if (cap_s && !in_range_s) begin
      idx_err_r <= 1'b1;
    end
  end
`else
  logic unused_idx_s;

  // Upper index bits are deliberately discarded in the truncating build
  assign unused_idx_s = ^{bus.z_i, bus.z_j, MAX_IDX};
  assign wr_en_s      = cap_s;
  assign bus.idx_err  = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) next_state_s = COLLECT;
        else           next_state_s = IDLE;
      end
      COLLECT: begin
        if (bus.mm_done) next_state_s = DRAIN;
        else             next_state_s = COLLECT;
      end
      DRAIN: begin
        if (last_fire_s) next_state_s = IDLE;
        else             next_state_s = DRAIN;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode; a capture is blocked while the previous ack is high
  always_comb begin
    busy_s     = 1'b0;
    clr_s      = 1'b0;
    cap_s      = 1'b0;
    drain_go_s = 1'b0;
    fire_s     = 1'b0;
    case (state_r)
      IDLE: begin
        clr_s = bus.start;
      end
      COLLECT: begin
        busy_s     = 1'b1;
        cap_s      = bus.z_stb && !z_ack_r;
        drain_go_s = bus.mm_done;
      end
      DRAIN: begin
        busy_s = 1'b1;
        fire_s = out_valid_r && bus.out_ready;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign last_s      = (row_r == LAST_RC) && (col_r == LAST_RC);
  assign last_fire_s = fire_s && last_s;

  // Drain position following the current one (row-major, column wraps first)
  always_comb begin
    if (col_r == LAST_RC) begin
      nxt_col_s = {AW{1'b0}};
      nxt_row_s = row_r + AW'(1);
    end else begin
      nxt_col_s = col_r + AW'(1);
      nxt_row_s = row_r;
    end
  end

  // Read port looks one element ahead during drain, element (0,0) otherwise
  always_comb begin
    if (state_r == DRAIN) begin
      rd_row_s = nxt_row_s;
      rd_col_s = nxt_col_s;
    end else begin
      rd_row_s = {AW{1'b0}};
      rd_col_s = {AW{1'b0}};
    end
  end

  // A capture to (0,0) on the same edge as done must appear as the first word
  always_comb begin
    if (wr_en_s && (wr_row_s == {AW{1'b0}}) && (wr_col_s == {AW{1'b0}})) begin
      first_data_s = bus.z_in;
    end else begin
      first_data_s = rd_data_s;
    end
  end

  matrix_regfile #(
    .M      (M),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .we      (wr_en_s),
    .wr_row  (wr_row_s),
    .wr_col  (wr_col_s),
    .wr_data (bus.z_in),
    .rd_row  (rd_row_s),
    .rd_col  (rd_col_s),
    .rd_data (rd_data_s)
  );

  // Capture handshake: one-cycle ack per capture, saturating capture count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_ack_r    <= 1'b0;
      wr_count_r <= 16'h0000;
    end else begin
      z_ack_r <= cap_s;
      if (clr_s) begin
        wr_count_r <= 16'h0000;
      end else if (wr_en_s && (wr_count_r != 16'hFFFF)) begin
        wr_count_r <= wr_count_r + 16'h0001;
      end
    end
  end

  // Drain stream: load (0,0) on done, advance on each accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      row_r       <= {AW{1'b0}};
      col_r       <= {AW{1'b0}};
    end else if (drain_go_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= (M == 1);
      out_data_r  <= first_data_s;
      row_r       <= {AW{1'b0}};
      col_r       <= {AW{1'b0}};
    end else if (fire_s) begin
      if (last_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        out_data_r  <= {DATA_W{1'b0}};
        row_r       <= {AW{1'b0}};
        col_r       <= {AW{1'b0}};
      end else begin
        out_valid_r <= 1'b1;
        out_last_r  <= (nxt_row_s == LAST_RC) && (nxt_col_s == LAST_RC);
        out_data_r  <= rd_data_s;
        row_r       <= nxt_row_s;
        col_r       <= nxt_col_s;
      end
    end
  end

  assign bus.z_ack     = z_ack_r;
  assign bus.wr_count  = wr_count_r;
  assign bus.busy      = busy_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_row   = IDX_W'(row_r);
  assign bus.out_col   = IDX_W'(col_r);

endmodule
